// File: rtl/aes128_enc_ctrl_pkg.sv
// aes_pkg: FSM state type, round count, round constants and GF(2^8) helpers shared by the AES-128 controller
package aes_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;
  localparam int NR = 10;
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction
  // multiplicative inverse as b^254 (zero maps to zero), then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv, sq;
    inv = 8'h01;
    sq = b;
    for (int i = 0; i < 8; i++) begin
      inv = (i == 0) ? inv : gmul(inv, sq);
      sq = gmul(sq, sq);
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction
endpackage

// File: rtl/aes128_enc_ctrl_if.sv
// aes128_enc_ctrl_if: start handshake, key/plaintext inputs and ciphertext result of the AES-128 controller
interface aes128_enc_ctrl_if;
  logic start;
  logic [127:0] key_in;
  logic [127:0] data_in;
  logic ready;
  logic busy;
  logic valid_out;
  logic [127:0] data_out;
  modport master (output start, key_in, data_in, input ready, busy, valid_out, data_out);
  modport slave (input start, key_in, data_in, output ready, busy, valid_out, data_out);
endinterface

// File: rtl/aes128_enc_ctrl_round.sv
// aes128_enc_ctrl_round: combinational AES round datapath on a row-major state (byte 4*row+col at the MSB end)
module state (
  input  logic [127:0] a,
  output logic [127:0] y
);
  // transpose between FIPS column order and row-major order; it is its own inverse
  for (genvar r = 0; r < 4; r++) begin : g_r
    for (genvar c = 0; c < 4; c++) begin : g_c
      assign y[127-8*(4*r+c) -: 8] = a[127-8*(r+4*c) -: 8];
    end
  end
endmodule

module sub_bytes
  import aes_pkg::*;
(
  input  logic [127:0] a,
  output logic [127:0] y
);
  for (genvar i = 0; i < 16; i++) begin : g_b
    assign y[8*i+7 -: 8] = sbox(a[8*i+7 -: 8]);
  end
endmodule

module shift_rows #(
  parameter bit EN = 1'b1
) (
  input  logic [127:0] a,
  output logic [127:0] y
);
  for (genvar r = 0; r < 4; r++) begin : g_r
    for (genvar c = 0; c < 4; c++) begin : g_c
      assign y[127-8*(4*r+c) -: 8] = EN ? a[127-8*(4*r+(c+r)%4) -: 8] : a[127-8*(4*r+c) -: 8];
    end
  end
endmodule

module mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] a,
  output logic [127:0] y
);
  for (genvar c = 0; c < 4; c++) begin : g_c
    logic [7:0] b0, b1, b2, b3;
    assign b0 = a[127-8*c -: 8];
    assign b1 = a[127-8*(4+c) -: 8];
    assign b2 = a[127-8*(8+c) -: 8];
    assign b3 = a[127-8*(12+c) -: 8];
    assign y[127-8*c -: 8]      = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
    assign y[127-8*(4+c) -: 8]  = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
    assign y[127-8*(8+c) -: 8]  = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
    assign y[127-8*(12+c) -: 8] = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
  end
endmodule

module key_expand_step
  import aes_pkg::*;
(
  input  logic [127:0] rk,
  input  logic [7:0]   rc,
  output logic [127:0] nk
);
  logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
  assign {w0, w1, w2, w3} = rk;
  assign t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign nk = {n0, n1, n2, n3};
endmodule

// File: rtl/aes128_enc_ctrl.sv
// aes128_enc_ctrl: iterative AES-128 encryption, one round per clock with on-the-fly key expansion
module aes128_enc_ctrl
  import aes_pkg::*;
#(
  parameter bit OUT_HOLD = 1'b1
) (
  input logic clk,
  input logic rst,
  aes128_enc_ctrl_if.slave bus
);
  fsm_t fsm;
  logic [127:0] st, rk, nk, din_s, key_s, nk_s, st_f, sb, sr, mc, rnd_st;
  logic [3:0] rnd;
  state u_din (.a(bus.data_in), .y(din_s));
  state u_key (.a(bus.key_in), .y(key_s));
  state u_nk (.a(nk), .y(nk_s));
  state u_out (.a(st), .y(st_f));
  sub_bytes u_sb (.a(st), .y(sb));
  shift_rows #(.EN(1'b1)) u_sr (.a(sb), .y(sr));
  mix_columns u_mc (.a(sr), .y(mc));
  key_expand_step u_kx (.rk(rk), .rc(rcon(rnd)), .nk(nk));
  // the final round skips MixColumns
  assign rnd_st = ((rnd == 4'(NR)) ? sr : mc) ^ nk_s;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm           <= IDLE;
      st            <= '0;
      rk            <= '0;
      rnd           <= '0;
      bus.ready     <= 1'b1;
      bus.busy      <= 1'b0;
      bus.valid_out <= 1'b0;
      bus.data_out  <= '0;
    end else begin
      bus.valid_out <= 1'b0;
      bus.data_out  <= OUT_HOLD ? bus.data_out : '0;
      case (fsm)
        IDLE: if (bus.start) begin
          st        <= din_s ^ key_s;
          rk        <= bus.key_in;
          rnd       <= 4'd1;
          fsm       <= ROUND;
          bus.ready <= 1'b0;
          bus.busy  <= 1'b1;
        end
        ROUND: if (rnd > 4'(NR)) begin
          fsm       <= IDLE;
          bus.ready <= 1'b1;
          bus.busy  <= 1'b0;
        end else begin
          st  <= rnd_st;
          rk  <= nk;
          rnd <= rnd + 4'd1;
          fsm      <= (rnd == 4'(NR)) ? DONE : ROUND;
          bus.busy <= (rnd != 4'(NR));
        end
        DONE: begin
          fsm           <= IDLE;
          bus.ready     <= 1'b1;
          bus.valid_out <= 1'b1;
          bus.data_out  <= st_f;
        end
        default: begin
          fsm       <= IDLE;
          bus.ready <= 1'b1;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_enc_ctrl.sv
// tb_aes128_enc_ctrl: randomized and directed checks of both OUT_HOLD variants against a behavioural AES model
module tb_aes128_enc_ctrl;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [127:0] key = '0, pt = '0;
  int checks = 0, failures = 0;
  logic [7:0] sbt [256];
  logic [7:0] bp, bq;

  aes128_enc_ctrl_if bus1 ();
  aes128_enc_ctrl_if bus0 ();
  assign bus1.start = start;
  assign bus1.key_in = key;
  assign bus1.data_in = pt;
  assign bus0.start = start;
  assign bus0.key_in = key;
  assign bus0.data_in = pt;
  aes128_enc_ctrl #(.OUT_HOLD(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  aes128_enc_ctrl #(.OUT_HOLD(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] x2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // textbook AES-128 on a 4x4 byte array, stopping after nr rounds
  function automatic logic [127:0] aes_enc(input logic [127:0] kk, input logic [127:0] pp, input int nr);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc, a0, a1, a2, a3;
    logic [7:0] s [4][4];
    logic [7:0] u [4][4];
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 44; i++) begin
      if (i < 4) w[i] = kk[127-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % 4 == 0) begin
          t = {sbt[t[23:16]] ^ rc, sbt[t[15:8]], sbt[t[7:0]], sbt[t[31:24]]};
          rc = x2(rc);
        end
        w[i] = w[i-4] ^ t;
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = pp[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          u[r][c] = sbt[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        a0 = u[0][c]; a1 = u[1][c]; a2 = u[2][c]; a3 = u[3][c];
        s[0][c] = (rd < 10) ? x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3 : a0;
        s[1][c] = (rd < 10) ? a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3 : a1;
        s[2][c] = (rd < 10) ? a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3 : a2;
        s[3][c] = (rd < 10) ? x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3) : a3;
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = s[r][c] ^ w[4*rd+c][31-8*r -: 8];
    end
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[r][c];
    return o;
  endfunction

  // transaction-level model: k is the edge that accepted the current block
  bit act = 1'b0;
  int ec = 0, k = 0, dd = 0;
  logic [127:0] cur = '0, hold = '0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      act = 1'b0;
      hold = '0;
    end else begin
      ec++;
      if (act && ec - k == 11) hold = cur;
      if ((!act || ec - k >= 12) && start) begin
        act = 1'b1;
        k = ec;
        cur = aes_enc(key, pt, 10);
      end
    end
  end

  always @(negedge clk) begin
    dd = ec - k;
    chk("ready1", bus1.ready, !(act && dd <= 10));
    chk("busy1", bus1.busy, act && dd <= 9);
    chk("valid1", bus1.valid_out, act && dd == 11);
    chk("data1", bus1.data_out, hold);
    chk("ready0", bus0.ready, !(act && dd <= 10));
    chk("busy0", bus0.busy, act && dd <= 9);
    chk("valid0", bus0.valid_out, act && dd == 11);
    chk("data0", bus0.data_out, (act && dd == 11) ? cur : 128'h0);
  end

  task automatic run_one(input logic [127:0] kk, input logic [127:0] pp, output int lat, output logic [127:0] ct);
    key = kk;
    pt = pp;
    start = 1'b1;
    lat = -1;
    ct = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      pt = rnd128();
      if (bus1.valid_out) begin
        lat = i - 1;
        ct = bus1.data_out;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  int lat, nv, t1, t2;
  logic [127:0] ct, c1, c2;
  bit swapped;
  initial begin
    bp = 8'h01;
    bq = 8'h01;
    do begin
      bp = bp ^ (bp << 1) ^ (bp[7] ? 8'h1b : 8'h00);
      bq = bq ^ (bq << 1);
      bq = bq ^ (bq << 2);
      bq = bq ^ (bq << 4);
      bq = bq[7] ? bq ^ 8'h09 : bq;
      sbt[bp] = bq ^ rl(bq, 1) ^ rl(bq, 2) ^ rl(bq, 3) ^ rl(bq, 4) ^ 8'h63;
    end while (bp != 8'h01);
    sbt[0] = 8'h63;
    chk("model_b_r0", aes_enc(KB, PB, 0), 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk("model_b_r1", aes_enc(KB, PB, 1), 128'ha49c7ff2689f352b6b5bea43026a5049);
    chk("model_b", aes_enc(KB, PB, 10), CB);
    chk("model_c", aes_enc(KC, PC, 10), CC);
    repeat (3) @(negedge clk);
    chk("rst_ready", bus1.ready, 1'b1);
    chk("rst_busy", bus1.busy, 1'b0);
    chk("rst_valid", bus1.valid_out, 1'b0);
    chk("rst_data", bus1.data_out, 128'h0);
    #2 rst = 1'b0;
    @(negedge clk);
    run_one(KB, PB, lat, ct);
    chk("lat_b", lat, 11);
    chk("ct_b", ct, CB);
    run_one(KC, PC, lat, ct);
    chk("lat_c", lat, 11);
    chk("ct_c", ct, CC);
    repeat (3) @(negedge clk);
    chk("hold1", bus1.data_out, CC);
    chk("hold0", bus0.data_out, 128'h0);
    // start held high across two blocks; the second vector is loaded while the first is busy
    key = KB; pt = PB; start = 1'b1;
    nv = 0; t1 = 0; t2 = 0; c1 = '0; c2 = '0; swapped = 1'b0;
    for (int i = 1; i <= 40 && nv < 2; i++) begin
      @(negedge clk);
      if (!swapped && bus1.busy) begin key = KC; pt = PC; swapped = 1'b1; end
      if (bus1.valid_out) begin
        if (nv == 0) begin t1 = i; c1 = bus1.data_out; end
        else begin t2 = i; c2 = bus1.data_out; end
        nv++;
      end
      if (nv == 1 && bus1.busy) begin start = 1'b0; pt = rnd128(); end
    end
    start = 1'b0;
    chk("b2b_count", nv, 2);
    chk("b2b_gap", t2 - t1, 12);
    chk("b2b_ct1", c1, CB);
    chk("b2b_ct2", c2, CC);
    // a second start during the rounds must be ignored
    key = rnd128(); pt = rnd128(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    key = rnd128(); pt = rnd128(); start = 1'b1;
    @(negedge clk);
    chk("ready_in_round", bus1.ready, 1'b0);
    start = 1'b0;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus1.valid_out) nv++;
    end
    chk("single_valid", nv, 1);
    // asynchronous reset in round 5
    key = KB; pt = PB; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", bus1.ready, 1'b1);
    chk("arst_busy", bus1.busy, 1'b0);
    chk("arst_valid", bus1.valid_out, 1'b0);
    chk("arst_data1", bus1.data_out, 128'h0);
    chk("arst_data0", bus0.data_out, 128'h0);
    nv = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus1.valid_out || bus0.valid_out) nv++;
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus1.valid_out || bus0.valid_out) nv++;
    end
    chk("arst_no_valid", nv, 0);
    run_one(KB, PB, lat, ct);
    chk("lat_after_rst", lat, 11);
    chk("ct_after_rst", ct, CB);
    // random traffic, checked every cycle by the compare process
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin key = rnd128(); pt = rnd128(); end
      if (i == 300) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    start = 1'b0;
    repeat (15) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes128_enc_ctrl.md
# aes128_enc_ctrl

Iterative AES-128 encryption controller that sequences the existing combinational round datapath (`state`, `sub_bytes`, `shift_rows`, `mix_columns`, AddRoundKey) over one 128-bit state register, one round per clock. It accepts a plaintext/key pair on a start handshake, expands round keys on the fly, and presents the ciphertext with a one-cycle `valid_out` pulse. It sits between the system bus wrapper and the round datapath modules.

## Interface
- `OUT_HOLD`, default 1: 1 = `data_out` holds the last ciphertext until the next result; 0 = `data_out` reads zero whenever `valid_out` is low.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled only when `ready`=1.
- `key_in` input 128: cipher key in FIPS-197 byte order (byte 0 at [127:120]); sampled with `start`.
- `data_in` input 128: plaintext in FIPS-197 byte order; sampled with `start`.
- `ready` output 1: high in IDLE; the controller accepts `start`.
- `busy` output 1: high while rounds are executing.
- `valid_out` output 1: one-cycle pulse; `data_out` holds a new ciphertext.
- `data_out` output 128: ciphertext in FIPS-197 byte order.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE: `ready`=1. On `start`, the block:
  - loads `st <= state(data_in) ^ state(key_in)` (round-0 AddRoundKey);
  - loads `rk <= key_in`;
  - sets `rnd <= 1`;
  - goes to ROUND.
- ROUND: each edge computes `nk = key_expand_step(rk, rcon[rnd])`. For `rnd` 1..9: `st <= mix_columns(shift_rows(sub_bytes(st))) ^ state(nk)`. For `rnd`=10, MixColumns is bypassed. Every edge also updates `rk <= nk` and `rnd <= rnd+1`. After `rnd`=10, the FSM goes to DONE.
- DONE: one cycle. `valid_out`=1 and `data_out = state(st)`, transposed back to FIPS order. The FSM returns to IDLE on the next edge.
- `start` is ignored while `ready`=0. There is no queueing and no error flag.
- `start` in the IDLE cycle directly after DONE is accepted normally, giving back-to-back operation.
- `rnd` is 4 bits, ranges 1..10 in ROUND, and never wraps. Values 11..15 are unreachable; if one occurs, the FSM forces IDLE.
- `rcon` is indexed by `rnd`: 01,02,04,08,10,20,40,80,1b,36.
- Reset mid-operation aborts the operation. The in-flight result is lost and never flagged valid.

## Timing
- Reset values: `ready`=1, `busy`=0, `valid_out`=0, `data_out`=0. State, `rk` and `rnd` all reset to 0; the FSM resets to IDLE.
- Latency: `start` is sampled at edge k. Rounds 1..10 complete at edges k+1..k+10. `valid_out` is high during the cycle after edge k+11 (DONE registered at edge k+10, output registered at k+11). Ten-cycle busy window.
- Throughput: one block per 12 cycles with `start` held high continuously.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `busy` and `ready` are mutually exclusive. Both are 0 in DONE.

## Structure
- Package `aes_pkg` holds:
  - the FSM state enum;
  - the `NR`=10 constant;
  - the `rcon` function/table;
  - the byte-order helper, if it is not taken from `state`.
- Sub-module `key_expand_step` (combinational) takes `rk` and `rcon` and returns the next round key. It applies RotWord and SubWord on word 3 using the shared S-box, then XOR-chains the words.
- The controller instantiates `state` (for entry/exit ordering), `sub_bytes`, `shift_rows` with EN=1, `mix_columns`, and `key_expand_step`. The final-round MixColumns bypass is a mux in the controller.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> `data_out` 3925841d02dc09fbdc118597196a0b32, `valid_out` exactly 11 cycles after the start edge. Internal state after load is 193de3bea0f4e22b9ac68d2ae9f84808; after round 1 it is a49c7ff2689f352b6b5bea43026a5049.
- App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-to-back: `start` held high with vectors B then C.1 -> two `valid_out` pulses 12 cycles apart, correct ciphertexts. Changes to `data_in` while busy have no effect.
- `start` pulsed during ROUND -> ignored; single `valid_out`; `ready` stays 0 until after DONE.
- Assert `rst` at round 5 -> all outputs at reset values immediately (asynchronous); no `valid_out`. A following start with App. B gives the correct result.
- `OUT_HOLD`=0 -> `data_out`=0 except during the `valid_out` cycle. `OUT_HOLD`=1 -> value persists until the next result.
